uart_alu_frame_ctrl: RTL and testbench
======================================

Name: uart_alu_frame_ctrl

Overview:
Parametrised UART-to-ALU command framer. It receives bytes from the UART RX block and assembles a framed command: sync byte, operand A, operand B, opcode. Operands may be multi-byte. It issues one valid-qualified request to the ALU, latches the result for the LEDs, and optionally streams the result back through the UART TX block. It also adds sync checking, an inter-byte timeout and opcode validation.

Parameters:
NB_DATA, 8, operand/result width; must be a multiple of 8 in 8..32; NBYTES = NB_DATA/8
NB_OP, 6, ALU opcode width (1..8)
SYNC_BYTE, 8'hA5, required first byte of every frame
TIMEOUT, 50000, max clk cycles between consecutive bytes inside a frame
NB_TMO, 16, timeout counter width; must satisfy 2^NB_TMO > TIMEOUT
TX_EN, 1, 1 = echo result over TX; 0 = skip the TX phase

Ports:
clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_rx_data  in  8  received byte, valid when i_rx_done=1
i_rx_done  in  1  one-cycle strobe per received byte
o_alu_a  out  NB_DATA  operand A to ALU
o_alu_b  out  NB_DATA  operand B to ALU
o_alu_op  out  NB_OP  opcode to ALU
o_alu_valid  out  1  one-cycle request strobe to ALU
i_alu_result  in  NB_DATA  ALU result (combinational from ALU inputs)
o_result  out  NB_DATA  last latched result (LED drive)
o_result_valid  out  1  one-cycle pulse when o_result updates
o_tx_data  out  8  byte to TX block
o_tx_start  out  1  one-cycle TX start strobe
i_tx_done  in  1  one-cycle strobe, TX byte finished
o_busy  out  1  high in every state except IDLE
o_err_timeout  out  1  one-cycle pulse, frame dropped on timeout
o_err_opcode  out  1  one-cycle pulse, frame dropped on bad opcode byte

Behaviour:
- Reset values: all outputs, internal registers, byte index and timeout counter = 0; state = IDLE.
- FSM states: IDLE, RX_A, RX_B, RX_OP, EXEC, LATCH, TX_LOAD, TX_WAIT.
- IDLE:
  - i_rx_done with i_rx_data==SYNC_BYTE -> RX_A; byte index = 0; timeout counter = 0.
  - Any other byte is ignored silently and the FSM stays in IDLE.
- RX_A / RX_B:
  - Each i_rx_done stores the byte into byte position [index], LSB first, and increments index.
  - On the NBYTES-th byte -> next state (RX_B, then RX_OP); index = 0.
- Register handling: the operand registers for the current frame are cleared on sync acceptance. o_alu_a/b/op hold the last frame's values until EXEC of the next frame.
- RX_OP:
  - If byte[7:NB_OP] != 0 (when NB_OP<8) -> pulse o_err_opcode, go to IDLE, no ALU request.
  - Otherwise latch byte[NB_OP-1:0] -> EXEC.
- EXEC (1 cycle):
  - o_alu_a/b/op drive the assembled values (registered; stable from this cycle until the next EXEC).
  - o_alu_valid = 1 for exactly this cycle -> LATCH.
- LATCH (1 cycle):
  - o_result <= i_alu_result; o_result_valid pulses.
  - -> TX_LOAD if TX_EN else IDLE.
- TX_LOAD:
  - o_tx_data = o_result byte [index], LSB first; o_tx_start = 1 for one cycle -> TX_WAIT.
- TX_WAIT:
  - On i_tx_done: index+1; if index==NBYTES-1 -> IDLE, else -> TX_LOAD.
  - No timeout in TX_WAIT.
- Latency: last opcode byte strobe -> o_alu_valid next cycle -> o_result_valid cycle after that -> first o_tx_start the following cycle.
- Timeout:
  - Active only in RX_A/RX_B/RX_OP; the counter increments each cycle and clears on every i_rx_done.
  - On reaching TIMEOUT -> pulse o_err_timeout, go to IDLE, discard the partial frame. o_result and o_alu_* are unchanged.
- Boundary and error handling:
  - i_rx_done in EXEC/LATCH/TX_LOAD/TX_WAIT is ignored; the byte is lost and no error is raised.
  - i_rx_done coinciding with the timeout terminal count: the byte wins, the counter clears and there is no error.
  - A SYNC_BYTE value inside RX_A/RX_B/RX_OP is treated as data (no resync).
  - i_tx_done outside TX_WAIT is ignored.
  - Asserting i_rst_n low at any time, including mid-TX, immediately forces reset values; o_tx_start drops at once.
- Width rules: byte k of an operand occupies bits [8k+7:8k]; the result is serialised the same way; no sign handling.

Test Plan:
1. NB_DATA=8, TX_EN=1, RX A5,05,03,20; ALU model returns 08.
   -> o_alu_a=05, o_alu_b=03, o_alu_op=6'h20, one o_alu_valid pulse.
   -> o_result=08 with o_result_valid one cycle later.
   -> o_tx_start with o_tx_data=08; o_busy drops after i_tx_done.
2. NB_DATA=16, RX A5,34,12,02,00,20; model returns 1236.
   -> o_alu_a=1234, o_alu_b=0002.
   -> TX bytes 36 then 12, second o_tx_start only after first i_tx_done.
3. RX 11,22 then A5,01,01,20.
   -> first two bytes ignored, o_busy stays 0.
   -> frame processed normally, o_alu_a=01, o_alu_b=01.
4. TIMEOUT=100, RX A5,05 then idle 100 cycles.
   -> o_err_timeout pulse at cycle 100, state IDLE, o_result unchanged.
   -> byte at cycle 99 instead of 100: no error.
5. NB_OP=6, RX A5,01,02,E0.
   -> o_err_opcode pulse, no o_alu_valid, o_result unchanged.
6. Reset asserted during TX_WAIT of test 2.
   -> all outputs 0 immediately.
   -> after release, new frame A5,01,00,01,00,20 -> o_alu_a=0001, o_alu_b=0001.

Source files
------------

// File: rtl/uart_alu_frame_ctrl.sv
// Purpose : assembles UART RX bytes (sync, operand A, operand B, opcode) into one ALU request,
//           latches the ALU result for the LEDs and optionally echoes it back byte-wise over UART TX.
// Ports   : clk/i_rst_n; i_rx_data/i_rx_done from UART RX; o_alu_a/b/op/valid + i_alu_result to/from ALU;
//           o_result/o_result_valid to LEDs; o_tx_data/o_tx_start/i_tx_done to UART TX;
//           o_busy (not IDLE), o_err_timeout / o_err_opcode one-cycle drop indications.
module uart_alu_frame_ctrl #(
    parameter int         NB_DATA   = 8,
    parameter int         NB_OP     = 6,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 50000,
    parameter int         NB_TMO    = 16,
    parameter bit         TX_EN     = 1'b1
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic               o_alu_valid,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_result_valid,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_err_timeout,
    output logic               o_err_opcode
);
    localparam int NBYTES = NB_DATA / 8;

    typedef enum logic [2:0] {
        S_IDLE, S_RX_A, S_RX_B, S_RX_OP, S_EXEC, S_LATCH, S_TX_LOAD, S_TX_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [NB_TMO-1:0]  tmo_q, tmo_d;
    logic [NB_DATA-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [NB_DATA-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [NB_OP-1:0]   alu_op_q, alu_op_d;
    logic [NB_DATA-1:0] result_q, result_d;

    logic in_rx, last_byte, tmo_hit, op_bad;

    assign in_rx     = (state_q == S_RX_A) || (state_q == S_RX_B) || (state_q == S_RX_OP);
    assign last_byte = (idx_q == 2'(NBYTES - 1));
    // A byte arriving on the terminal count wins over the timeout.
    assign tmo_hit   = in_rx && !i_rx_done && (tmo_q == NB_TMO'(TIMEOUT - 1));
    // Opcode bits above NB_OP must be zero; with NB_OP==8 the shift yields 0.
    assign op_bad    = (i_rx_data >> NB_OP) != 8'd0;

    // State register
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            tmo_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            result_q <= result_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        result_d = result_q;

        // Inter-byte watchdog only runs while a frame is being received.
        if (in_rx) begin
            tmo_d = i_rx_done ? '0 : tmo_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_rx_done && (i_rx_data == SYNC_BYTE)) begin
                    state_d = S_RX_A;
                    idx_d   = 2'd0;
                    tmo_d   = '0;
                    opa_d   = '0;
                    opb_d   = '0;
                end
            end
            S_RX_A: begin
                if (i_rx_done) begin
                    for (int k = 0; k < NBYTES; k++) begin
                        if (idx_q == 2'(k)) opa_d[8*k +: 8] = i_rx_data;
                    end
                    idx_d   = last_byte ? 2'd0 : idx_q + 1'b1;
                    state_d = last_byte ? S_RX_B : S_RX_A;
                end
            end
            S_RX_B: begin
                if (i_rx_done) begin
                    for (int k = 0; k < NBYTES; k++) begin
                        if (idx_q == 2'(k)) opb_d[8*k +: 8] = i_rx_data;
                    end
                    idx_d   = last_byte ? 2'd0 : idx_q + 1'b1;
                    state_d = last_byte ? S_RX_OP : S_RX_B;
                end
            end
            S_RX_OP: begin
                if (i_rx_done) begin
                    if (op_bad) begin
                        state_d = S_IDLE;
                    end else begin
                        // ALU-facing registers only change here, so they hold between frames.
                        alu_a_d  = opa_q;
                        alu_b_d  = opb_q;
                        alu_op_d = i_rx_data[NB_OP-1:0];
                        state_d  = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                // Capture at the end of EXEC so o_result already shows the new value
                // during the LATCH cycle, alongside o_result_valid.
                result_d = i_alu_result;
                state_d  = S_LATCH;
            end
            S_LATCH: begin
                idx_d   = 2'd0;
                state_d = TX_EN ? S_TX_LOAD : S_IDLE;
            end
            S_TX_LOAD: begin
                state_d = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (i_tx_done) begin
                    idx_d   = last_byte ? 2'd0 : idx_q + 1'b1;
                    state_d = last_byte ? S_IDLE : S_TX_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (tmo_hit) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            tmo_d   = '0;
        end
    end

    // Output logic
    always_comb begin
        o_busy         = (state_q != S_IDLE);
        o_alu_valid    = (state_q == S_EXEC);
        o_result_valid = (state_q == S_LATCH);
        o_tx_start     = (state_q == S_TX_LOAD);
        o_tx_data      = 8'd0;
        if ((state_q == S_TX_LOAD) || (state_q == S_TX_WAIT)) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (idx_q == 2'(k)) o_tx_data = result_q[8*k +: 8];
            end
        end
        o_err_timeout  = tmo_hit;
        o_err_opcode   = (state_q == S_RX_OP) && i_rx_done && op_bad;
    end

    assign o_alu_a  = alu_a_q;
    assign o_alu_b  = alu_b_q;
    assign o_alu_op = alu_op_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Bench for uart_alu_frame_ctrl with 16-bit operands, 6-bit opcodes and a short inter-byte timeout.
// Stimulus is driven #1 after the rising edge; DUT outputs are captured on the falling edge.
// A behavioural ALU and an automatic TX-done responder model the surrounding blocks.
module tb_uart_alu_frame_ctrl;
    localparam int NB_DATA = 16;
    localparam int NB_OP   = 6;
    localparam int TIMEOUT = 100;

    typedef logic [7:0] bq_t[$];

    logic               clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic [7:0]         i_rx_data = 8'd0;
    logic               i_rx_done = 1'b0;
    logic [NB_DATA-1:0] o_alu_a, o_alu_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic               o_alu_valid;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_result;
    logic               o_result_valid;
    logic [7:0]         o_tx_data;
    logic               o_tx_start;
    logic               i_tx_done = 1'b0;
    logic               o_busy, o_err_timeout, o_err_opcode;

    uart_alu_frame_ctrl #(
        .NB_DATA(NB_DATA), .NB_OP(NB_OP), .SYNC_BYTE(8'hA5),
        .TIMEOUT(TIMEOUT), .NB_TMO(8), .TX_EN(1'b1)
    ) dut (
        .clk(clk), .i_rst_n(i_rst_n),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .o_alu_valid(o_alu_valid),
        .i_alu_result(i_alu_result),
        .o_result(o_result), .o_result_valid(o_result_valid),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .o_busy(o_busy), .o_err_timeout(o_err_timeout), .o_err_opcode(o_err_opcode)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ncmp = 0;
    int nfail = 0;
    int last_rx_c = 0;
    bit tx_auto = 1'b1;

    // Behavioural ALU
    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    assign i_alu_result = alu_fn(o_alu_a, o_alu_b, o_alu_op);

    // Event capture
    logic [15:0] m_a[$], m_b[$], m_res[$];
    logic [5:0]  m_op[$];
    logic [7:0]  m_tx[$];
    int          m_alu_c[$], m_res_c[$], m_tx_c[$], m_txd_c[$];
    int          m_tmo_n, m_tmo_c, m_op_n;

    always @(negedge clk) begin
        if (i_rst_n) begin
            if (o_alu_valid) begin
                m_a.push_back(o_alu_a); m_b.push_back(o_alu_b); m_op.push_back(o_alu_op);
                m_alu_c.push_back(cyc);
            end
            if (o_result_valid) begin m_res.push_back(o_result); m_res_c.push_back(cyc); end
            if (o_tx_start)     begin m_tx.push_back(o_tx_data); m_tx_c.push_back(cyc); end
            if (i_tx_done)      m_txd_c.push_back(cyc);
            if (o_err_timeout)  begin m_tmo_n++; m_tmo_c = cyc; end
            if (o_err_opcode)   m_op_n++;
        end
    end

    // TX block model: acknowledges each started byte after a random delay
    initial begin
        forever begin
            @(negedge clk);
            if (tx_auto && i_rst_n && o_tx_start) begin
                repeat (int'($urandom_range(1, 4))) @(posedge clk);
                #1 i_tx_done = 1'b1;
                @(posedge clk);
                #1 i_tx_done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        m_a.delete(); m_b.delete(); m_op.delete(); m_res.delete(); m_tx.delete();
        m_alu_c.delete(); m_res_c.delete(); m_tx_c.delete(); m_txd_c.delete();
        m_tmo_n = 0; m_tmo_c = 0; m_op_n = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin @(posedge clk); #1; end
        i_rx_data = b;
        i_rx_done = 1'b1;
        last_rx_c = cyc;
        @(posedge clk); #1;
        i_rx_done = 1'b0;
    endtask

    task automatic send_frame(input bq_t bytes, input int max_gap);
        foreach (bytes[i]) send_byte(bytes[i], int'($urandom_range(0, max_gap)));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (o_busy && n < 2000) begin @(posedge clk); #1; n++; end
        ncmp++;
        if (o_busy !== 1'b0) begin
            nfail++;
            $display("FAIL %s_idle: o_busy=%b after %0d cycles, required 0", name, o_busy, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        ncmp++;
        if ({o_alu_a, o_alu_b, o_alu_op, o_alu_valid} !== '0) begin
            nfail++; $display("FAIL reset_alu: a=%h b=%h op=%h v=%b, required all 0", o_alu_a, o_alu_b, o_alu_op, o_alu_valid);
        end
        ncmp++;
        if ({o_result, o_result_valid, o_tx_data, o_tx_start} !== '0) begin
            nfail++; $display("FAIL reset_res_tx: res=%h rv=%b txd=%h txs=%b, required all 0", o_result, o_result_valid, o_tx_data, o_tx_start);
        end
        repeat (3) @(posedge clk);
        #1 i_rst_n = 1'b1;
        @(posedge clk); #1;
        ncmp++;
        if ({o_busy, o_err_timeout, o_err_opcode} !== 3'b000) begin
            nfail++; $display("FAIL reset_flags: busy=%b tmo=%b op=%b, required 000", o_busy, o_err_timeout, o_err_opcode);
        end
    endtask

    task automatic test_basic();
        bq_t f;
        int  rx_c;
        clear_mon();
        f = '{8'hA5, 8'h05, 8'h00, 8'h03, 8'h00, 8'h20};
        send_frame(f, 0);
        rx_c = last_rx_c;
        wait_idle("basic");
        ncmp++;
        if (m_a.size() != 1 || m_a[0] !== 16'h0005 || m_b[0] !== 16'h0003 || m_op[0] !== 6'h20) begin
            nfail++; $display("FAIL basic_alu: n=%0d a=%h b=%h op=%h, required 1 0005 0003 20", m_a.size(), m_a[0], m_b[0], m_op[0]);
        end
        ncmp++;
        if (m_alu_c.size() != 1 || m_alu_c[0] != rx_c + 1) begin
            nfail++; $display("FAIL basic_alu_lat: valid at %0d, required %0d", m_alu_c[0], rx_c + 1);
        end
        ncmp++;
        if (m_res.size() != 1 || m_res[0] !== 16'h0008 || m_res_c[0] != rx_c + 2) begin
            nfail++; $display("FAIL basic_result: res=%h at %0d, required 0008 at %0d", m_res[0], m_res_c[0], rx_c + 2);
        end
        ncmp++;
        if (m_tx.size() != 2 || m_tx[0] !== 8'h08 || m_tx[1] !== 8'h00 || m_tx_c[0] != rx_c + 3) begin
            nfail++; $display("FAIL basic_tx: n=%0d bytes=%h %h first at %0d, required 2 08 00 at %0d",
                              m_tx.size(), m_tx[0], m_tx[1], m_tx_c[0], rx_c + 3);
        end
        ncmp++;
        if (o_result !== 16'h0008) begin
            nfail++; $display("FAIL basic_hold: o_result=%h, required 0008", o_result);
        end
    endtask

    task automatic test_multibyte();
        bq_t f;
        clear_mon();
        f = '{8'hA5, 8'h34, 8'h12, 8'h02, 8'h00, 8'h20};
        send_frame(f, 2);
        wait_idle("multi");
        ncmp++;
        if (m_a.size() != 1 || m_a[0] !== 16'h1234 || m_b[0] !== 16'h0002) begin
            nfail++; $display("FAIL multi_alu: a=%h b=%h, required 1234 0002", m_a[0], m_b[0]);
        end
        ncmp++;
        if (m_res.size() != 1 || m_res[0] !== 16'h1236) begin
            nfail++; $display("FAIL multi_result: res=%h, required 1236", m_res[0]);
        end
        ncmp++;
        if (m_tx.size() != 2 || m_tx[0] !== 8'h36 || m_tx[1] !== 8'h12) begin
            nfail++; $display("FAIL multi_tx: n=%0d bytes=%h %h, required 36 12", m_tx.size(), m_tx[0], m_tx[1]);
        end
        ncmp++;
        if (m_txd_c.size() < 1 || m_tx_c.size() != 2 || m_tx_c[1] != m_txd_c[0] + 1) begin
            nfail++; $display("FAIL multi_tx_order: second start at %0d, required %0d", m_tx_c[1], m_txd_c[0] + 1);
        end
    endtask

    task automatic test_sync_skip();
        bq_t f;
        clear_mon();
        send_byte(8'h11, 2);
        ncmp++;
        if (o_busy !== 1'b0) begin nfail++; $display("FAIL skip_busy0: o_busy=%b, required 0", o_busy); end
        send_byte(8'h22, 1);
        ncmp++;
        if (o_busy !== 1'b0) begin nfail++; $display("FAIL skip_busy1: o_busy=%b, required 0", o_busy); end
        f = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h20};
        send_frame(f, 2);
        wait_idle("skip");
        ncmp++;
        if (m_a.size() != 1 || m_a[0] !== 16'h0001 || m_b[0] !== 16'h0001 || m_res[0] !== 16'h0002) begin
            nfail++; $display("FAIL skip_frame: n=%0d a=%h b=%h res=%h, required 1 0001 0001 0002", m_a.size(), m_a[0], m_b[0], m_res[0]);
        end
    endtask

    task automatic test_bad_opcode();
        bq_t         f;
        logic [15:0] prev;
        clear_mon();
        prev = o_result;
        f = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'h00, 8'hE0};
        send_frame(f, 1);
        wait_idle("badop");
        ncmp++;
        if (m_op_n != 1) begin nfail++; $display("FAIL badop_pulse: pulses=%0d, required 1", m_op_n); end
        ncmp++;
        if (m_a.size() != 0 || m_res.size() != 0 || o_result !== prev) begin
            nfail++; $display("FAIL badop_nores: alu=%0d res=%0d o_result=%h, required 0 0 %h", m_a.size(), m_res.size(), o_result, prev);
        end
    endtask

    task automatic test_timeout();
        bq_t         f;
        int          rx_c;
        logic [15:0] prev;
        clear_mon();
        prev = o_result;
        f = '{8'hA5, 8'h05};
        send_frame(f, 0);
        rx_c = last_rx_c;
        repeat (TIMEOUT + 5) begin @(posedge clk); #1; end
        ncmp++;
        if (m_tmo_n != 1 || m_tmo_c != rx_c + TIMEOUT) begin
            nfail++; $display("FAIL tmo_pulse: pulses=%0d at %0d, required 1 at %0d", m_tmo_n, m_tmo_c, rx_c + TIMEOUT);
        end
        ncmp++;
        if (o_busy !== 1'b0 || o_result !== prev || m_a.size() != 0) begin
            nfail++; $display("FAIL tmo_state: busy=%b res=%h alu=%0d, required 0 %h 0", o_busy, o_result, m_a.size(), prev);
        end
        // Bytes 99 and 100 cycles after their predecessor must both be accepted.
        clear_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h05, 0);
        send_byte(8'h00, TIMEOUT - 2);
        send_byte(8'h07, TIMEOUT - 1);
        send_byte(8'h00, 0);
        send_byte(8'h20, 0);
        wait_idle("tmo_edge");
        ncmp++;
        if (m_tmo_n != 0) begin nfail++; $display("FAIL tmo_edge_err: pulses=%0d, required 0", m_tmo_n); end
        ncmp++;
        if (m_a.size() != 1 || m_a[0] !== 16'h0005 || m_b[0] !== 16'h0007 || m_res[0] !== 16'h000C) begin
            nfail++; $display("FAIL tmo_edge_frame: n=%0d a=%h b=%h res=%h, required 1 0005 0007 000c", m_a.size(), m_a[0], m_b[0], m_res[0]);
        end
    endtask

    task automatic test_random();
        bq_t         f;
        logic [15:0] a, b, exp, prev;
        logic [7:0]  opb, jb;
        int          nj;
        for (int it = 0; it < 24; it++) begin
            clear_mon();
            prev = o_result;
            a    = 16'($urandom);
            b    = 16'($urandom);
            opb  = ($urandom_range(0, 9) < 3) ? {2'($urandom_range(1, 3)), 6'($urandom)} : {2'b00, 6'($urandom)};
            nj   = int'($urandom_range(0, 2));
            for (int j = 0; j < nj; j++) begin
                jb = 8'($urandom);
                if (jb == 8'hA5) jb = 8'h5A;
                send_byte(jb, int'($urandom_range(0, 3)));
            end
            f = '{8'hA5, a[7:0], a[15:8], b[7:0], b[15:8], opb};
            send_frame(f, 3);
            wait_idle("rand");
            if (opb[7:6] != 2'b00) begin
                ncmp++;
                if (m_op_n != 1 || m_a.size() != 0 || o_result !== prev) begin
                    nfail++; $display("FAIL rand_badop[%0d]: err=%0d alu=%0d res=%h, required 1 0 %h", it, m_op_n, m_a.size(), o_result, prev);
                end
            end else begin
                exp = alu_fn(a, b, opb[5:0]);
                ncmp++;
                if (m_a.size() != 1 || m_a[0] !== a || m_b[0] !== b || m_op[0] !== opb[5:0] || m_op_n != 0) begin
                    nfail++; $display("FAIL rand_alu[%0d]: a=%h b=%h op=%h, required %h %h %h", it, m_a[0], m_b[0], m_op[0], a, b, opb[5:0]);
                end
                ncmp++;
                if (m_res.size() != 1 || m_res[0] !== exp || m_tx.size() != 2 || m_tx[0] !== exp[7:0] || m_tx[1] !== exp[15:8]) begin
                    nfail++; $display("FAIL rand_res[%0d]: res=%h tx=%h %h, required %h", it, m_res[0], m_tx[1], m_tx[0], exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_tx();
        bq_t f;
        int  n;
        tx_auto = 1'b0;
        clear_mon();
        f = '{8'hA5, 8'h34, 8'h12, 8'h02, 8'h00, 8'h20};
        send_frame(f, 0);
        n = 0;
        while (!o_tx_start && n < 20) begin @(posedge clk); #1; n++; end
        ncmp++;
        if (o_tx_start !== 1'b1) begin nfail++; $display("FAIL rst_tx_start: o_tx_start=%b, required 1", o_tx_start); end
        @(posedge clk); #1;
        #2 i_rst_n = 1'b0;
        #1;
        ncmp++;
        if ({o_alu_a, o_alu_b, o_alu_op, o_alu_valid, o_result, o_result_valid,
             o_tx_data, o_tx_start, o_busy, o_err_timeout, o_err_opcode} !== '0) begin
            nfail++; $display("FAIL rst_mid_tx: a=%h b=%h res=%h txd=%h txs=%b busy=%b, required all 0",
                              o_alu_a, o_alu_b, o_result, o_tx_data, o_tx_start, o_busy);
        end
        repeat (2) @(posedge clk);
        #1 i_rst_n = 1'b1;
        tx_auto = 1'b1;
        @(posedge clk); #1;
        clear_mon();
        f = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h20};
        send_frame(f, 1);
        wait_idle("rst_after");
        ncmp++;
        if (m_a.size() != 1 || m_a[0] !== 16'h0001 || m_b[0] !== 16'h0001 || m_res[0] !== 16'h0002) begin
            nfail++; $display("FAIL rst_after_frame: n=%0d a=%h b=%h res=%h, required 1 0001 0001 0002", m_a.size(), m_a[0], m_b[0], m_res[0]);
        end
        ncmp++;
        if (m_tx.size() != 2 || m_tx[0] !== 8'h02 || m_tx[1] !== 8'h00) begin
            nfail++; $display("FAIL rst_after_tx: n=%0d bytes=%h %h, required 02 00", m_tx.size(), m_tx[0], m_tx[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multibyte();
        test_sync_skip();
        test_bad_opcode();
        test_timeout();
        test_random();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
